// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side memory arbiter: FSM states,
// arbitration mode codes, common byte-enable patterns and a width helper.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  // Bits needed to hold a wait count of 0..lat.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational request picker. Round-robin mode searches upward starting
// one past the pointer (wrapping); fixed mode takes the lowest requester.
module rr_picker
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [2:0]        idx,
  output logic              valid
);

  logic [7:0] req_ext;
  logic [2:0] cand;

  // First requester found in search order wins.
  always_comb begin
    req_ext = 8'(req);
    valid   = 1'b0;
    idx     = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (ARB_MODE == ARB_FIXED) cand = 3'(i - 1);
      else                       cand = 3'((int'(ptr) + i) % NUM_CH);
      if (!valid && req_ext[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

  // Expand the winner index into a one-hot vector.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_CH; k++) onehot[k] = valid && (idx == 3'(k));
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges NUM_CH CPU bus masters onto one single-port memory.
// Handshake: a master raises iReq with iWe/iAddr/iWData/iBE and holds them
// stable until it sees a one-cycle oAck pulse on its bit; read data is valid
// on oRData in that same cycle. iReq may stay high after oAck to start the
// next transaction, which re-arbitrates in the following IDLE cycle.
// Sequence per transaction: IDLE (grant) -> ISSUE (1 cycle memory strobe)
// -> WAIT (reads only, READ_LAT cycles total from ISSUE) -> DONE (ack).
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = ARB_RR,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [NUM_CH-1:0]        iReq,
  input  logic [NUM_CH-1:0]        iWe,
  input  logic [NUM_CH*ADDR_W-1:0] iAddr,
  input  logic [NUM_CH*DATA_W-1:0] iWData,
  input  logic [NUM_CH*BE_W-1:0]   iBE,
  output logic [NUM_CH-1:0]        oAck,
  output logic [DATA_W-1:0]        oRData,
  output logic                     oMemRE,
  output logic                     oMemWE,
  output logic [BE_W-1:0]          oMemBE,
  output logic [ADDR_W-1:0]        oMemAddr,
  output logic [DATA_W-1:0]        oMemWData,
  input  logic [DATA_W-1:0]        iMemRData,
  output logic                     oBusy,
  output logic [2:0]               oGrant,
  output logic [1:0]               oState
);

  localparam int CNT_W = cnt_width(READ_LAT);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("cpu_mem_arbiter: NUM_CH must be 1..8");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("cpu_mem_arbiter: DATA_W must be a positive multiple of 8");
  end
  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
    $error("cpu_mem_arbiter: READ_LAT must be 1..15");
  end
  if (ARB_MODE != ARB_RR && ARB_MODE != ARB_FIXED) begin : g_bad_arb_mode
    $error("cpu_mem_arbiter: ARB_MODE must be 0 or 1");
  end

  state_t            state;
  logic [2:0]        ptr;
  logic              h_we;
  logic [NUM_CH-1:0] h_oh;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_CH-1:0] pick_oh;
  logic [2:0]        pick_idx;
  logic              pick_valid;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  rr_picker #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_picker (
    .req    (iReq),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Route the winning channel's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_oh[i]) begin
        sel_we    = iWe[i];
        sel_addr  = iAddr[i*ADDR_W +: ADDR_W];
        sel_wdata = iWData[i*DATA_W +: DATA_W];
        sel_be    = iBE[i*BE_W +: BE_W];
      end
    end
  end

  // Transaction FSM; memory strobes and the ack are registered so each is
  // high for exactly the ISSUE or DONE cycle respectively.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= ST_IDLE;
      ptr       <= 3'(NUM_CH - 1);
      h_we      <= 1'b0;
      h_oh      <= '0;
      cnt       <= '0;
      oAck      <= '0;
      oRData    <= '0;
      oMemRE    <= 1'b0;
      oMemWE    <= 1'b0;
      oMemBE    <= '0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oGrant    <= '0;
    end else begin
      oAck <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state     <= ST_ISSUE;
            oGrant    <= pick_idx;
            h_oh      <= pick_oh;
            h_we      <= sel_we;
            oMemAddr  <= sel_addr;
            oMemWData <= sel_wdata;
            oMemBE    <= sel_be;
            oMemWE    <= sel_we;
            oMemRE    <= !sel_we;
            if (ARB_MODE == ARB_RR) ptr <= pick_idx;
          end
        end
        ST_ISSUE: begin
          oMemWE <= 1'b0;
          oMemRE <= 1'b0;
          oMemBE <= '0;
          if (h_we) begin
            state <= ST_DONE;
            oAck  <= h_oh;
          end else begin
            cnt   <= CNT_W'(READ_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            oRData <= iMemRData;
            oAck   <= h_oh;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oBusy  = (state != ST_IDLE);
  assign oState = state;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: three configurations run side by side
// (2ch/lat2/RR, 2ch/lat3/fixed, 4ch/lat1/RR). Each has a transaction-level
// reference that schedules grant, issue and ack cycles from the arbitration
// rules and latency arithmetic, and checks every DUT output every cycle.
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;
  import cpu_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by every instance.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h00A0_0093;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NCH  = (g == 2) ? 4 : 2;
    localparam int LAT  = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    localparam int MODE = (g == 1) ? ARB_FIXED : ARB_RR;

    logic              rst_n = 1'b1;
    logic [NCH-1:0]    req, we;
    logic [NCH*32-1:0] addr, wdata;
    logic [NCH*4-1:0]  be;
    logic [NCH-1:0]    ack;
    logic [31:0]       rdata, mem_addr, mem_wdata, mem_rdata;
    logic              mem_re, mem_we, busy;
    logic [3:0]        mem_be;
    logic [2:0]        grant;
    logic [1:0]        state;
    bit                fin = 1'b0;

    cpu_mem_arbiter #(
      .NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .READ_LAT(LAT), .ARB_MODE(MODE)
    ) dut (
      .iCLK(clk), .iRST(rst_n), .iReq(req), .iWe(we), .iAddr(addr),
      .iWData(wdata), .iBE(be), .oAck(ack), .oRData(rdata),
      .oMemRE(mem_re), .oMemWE(mem_we), .oMemBE(mem_be), .oMemAddr(mem_addr),
      .oMemWData(mem_wdata), .iMemRData(mem_rdata), .oBusy(busy),
      .oGrant(grant), .oState(state)
    );

    // Memory: data is valid only LAT cycles after the read strobe cycle.
    bit          pv [LAT];
    logic [31:0] pa [LAT];
    always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
      pv[0] <= mem_re;
      pa[0] <= mem_addr;
    end
    always_comb mem_rdata = pv[LAT-1] ? mem_fn(pa[LAT-1]) : ~mem_fn(pa[LAT-1]);

    // Master-side state.
    bit          pend    [NCH];
    bit          dropped [NCH];
    bit          m_we    [NCH];
    logic [31:0] m_addr  [NCH];
    logic [31:0] m_wdata [NCH];
    logic [3:0]  m_be    [NCH];

    // Reference model state.
    int          cyc = 0;
    bit          active;
    int          cur, s_c, iss_c, ack_c, free_at, ptr, exp_grant;
    bit          t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;
    logic [31:0] last_rd, exp_maddr, exp_mwdata;
    logic [31:0] exp_q[$];
    bit          rnd_en, armed, rel_pending;
    int          repost_left;
    string       pfx;

    // ---------------- driver tasks ----------------
    task automatic post(input int ch, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      pend[ch] = 1'b1; dropped[ch] = 1'b0;
      m_we[ch] = w; m_addr[ch] = a; m_wdata[ch] = d; m_be[ch] = b;
    endtask

    task automatic rand_post(input int ch, input bit force_read);
      logic [31:0] a;
      a = $urandom();
      a[1:0] = 2'b00;
      post(ch, force_read ? 1'b0 : 1'($urandom_range(0, 1)), a, $urandom(),
           4'($urandom_range(1, 15)));
    endtask

    task automatic drive();
      for (int ch = 0; ch < NCH; ch++) begin
        req[ch]            = pend[ch] && !dropped[ch];
        we[ch]             = m_we[ch];
        addr[ch*32 +: 32]  = m_addr[ch];
        wdata[ch*32 +: 32] = m_wdata[ch];
        be[ch*4 +: 4]      = m_be[ch];
      end
    endtask

    task automatic reinit_model();
      active = 1'b0; free_at = 0; ptr = NCH - 1; exp_grant = 0;
      last_rd = '0; exp_maddr = '0; exp_mwdata = '0; exp_q.delete();
      repost_left = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        pend[ch] = 1'b0; dropped[ch] = 1'b0; m_we[ch] = 1'b0;
        m_addr[ch] = '0; m_wdata[ch] = '0; m_be[ch] = '0;
      end
    endtask

    // Expected FSM phase for the current cycle, from the scheduled times.
    function automatic int exp_state();
      if (!active)         return 0;
      if (cyc == iss_c)    return 1;
      if (cyc == ack_c)    return 3;
      if (cyc > iss_c)     return 2;
      return 0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
      int st;
      logic [NCH-1:0] ack_e;
      st = exp_state();
      ack_e = '0;
      if (st == 3) ack_e[cur] = 1'b1;
      check_eq({pfx, "state"},     32'(state),     32'(st));
      check_eq({pfx, "busy"},      32'(busy),      32'(st != 0));
      check_eq({pfx, "mem_we"},    32'(mem_we),    32'(st == 1 && t_we));
      check_eq({pfx, "mem_re"},    32'(mem_re),    32'(st == 1 && !t_we));
      check_eq({pfx, "mem_be"},    32'(mem_be),    (st == 1) ? 32'(t_be) : 32'd0);
      check_eq({pfx, "mem_addr"},  mem_addr,       exp_maddr);
      check_eq({pfx, "mem_wdata"}, mem_wdata,      exp_mwdata);
      check_eq({pfx, "ack"},       32'(ack),       32'(ack_e));
      check_eq({pfx, "grant"},     32'(grant),     32'(exp_grant));
      check_eq({pfx, "rdata"},     rdata,          last_rd);
      if (st == 3 && !t_we && exp_q.size() > 0)
        check_eq({pfx, "rd_ack_data"}, rdata, exp_q.pop_front());
    endtask

    // Grant decision when the arbiter is idle, from the arbitration rules.
    task automatic arbitrate();
      int w, c2;
      w = -1;
      if (active || cyc < free_at) return;
      for (int k = 1; k <= NCH; k++) begin
        c2 = (MODE == ARB_FIXED) ? (k - 1) : ((ptr + k) % NCH);
        if (w < 0 && pend[c2] && !dropped[c2]) w = c2;
      end
      if (w < 0) return;
      if (MODE == ARB_RR) ptr = w;
      cur = w; active = 1'b1;
      t_we = m_we[w]; t_addr = m_addr[w]; t_wdata = m_wdata[w]; t_be = m_be[w];
      s_c = cyc; iss_c = cyc + 1;
      ack_c = cyc + 2 + (t_we ? 0 : LAT);
      free_at = ack_c + 1;
      if (!t_we) exp_q.push_back(mem_fn(t_addr));
    endtask

    task automatic step();
      @(negedge clk);
      if (rel_pending) begin
        rst_n = 1'b1;
        rel_pending = 1'b0;
      end
      cyc++;
      if (active && cyc == iss_c) begin
        exp_maddr = t_addr; exp_mwdata = t_wdata; exp_grant = cur;
      end
      if (active && cyc == ack_c && !t_we) last_rd = mem_fn(t_addr);
      check_outputs();
      if (active && cyc == ack_c) begin
        pend[cur] = 1'b0; dropped[cur] = 1'b0; active = 1'b0;
        if (repost_left > 0) begin
          repost_left--;
          rand_post(cur, 1'b1);
        end
      end
      if (rnd_en) begin
        for (int ch = 0; ch < NCH; ch++)
          if (!pend[ch] && $urandom_range(0, 2) == 0) rand_post(ch, 1'b0);
        if (active && cyc > s_c && cyc < ack_c && !dropped[cur] &&
            $urandom_range(0, 15) == 0) dropped[cur] = 1'b1;
      end
      drive();
      arbitrate();
    endtask

    // Asynchronous reset: outputs must clear at once; released next step.
    task automatic do_reset();
      rst_n = 1'b0;
      #1;
      reinit_model();
      check_outputs();
      rel_pending = 1'b1;
      drive();
    endtask

    task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
        step();
        if (armed && exp_state() == 2) begin
          armed = 1'b0;
          do_reset();
          for (int ch = 0; ch < NCH; ch++) rand_post(ch, 1'b1);
          drive();
        end
      end
    endtask

    task automatic wait_idle();
      int guard, left;
      guard = 0;
      do begin
        step();
        guard++;
        left = active ? 1 : 0;
        for (int ch = 0; ch < NCH; ch++) if (pend[ch]) left++;
      end while (left != 0 && guard < 400);
      check_eq({pfx, "drain"}, 32'(left), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
      pfx = $sformatf("u%0d.", g);
      rnd_en = 1'b0; armed = 1'b0; rel_pending = 1'b0;
      reinit_model();
      drive();
      #2 rst_n = 1'b0;
      @(negedge clk);
      do_reset();

      post(NCH - 1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, BE_WORD);
      wait_idle();
      post(0, 1'b0, 32'h0040_0000, 32'h0, BE_WORD);
      wait_idle();

      for (int ch = 0; ch < NCH; ch++) rand_post(ch, 1'b1);
      repost_left = 3 * NCH;
      wait_idle();

      post(1 % NCH, 1'b1, 32'h1001_0008, 32'h1122_3344, 4'b0100);
      post(0, 1'b0, 32'h0040_0000, 32'h0, BE_WORD);
      wait_idle();

      rand_post(1 % NCH, 1'b1);
      wait_idle();
      rand_post(3 % NCH, 1'b1);
      rand_post(1 % NCH, 1'b1);
      wait_idle();

      rnd_en = 1'b1;
      run(200);
      armed = 1'b1;
      run(100);
      run(200);
      rnd_en = 1'b0;
      wait_idle();
      fin = 1'b1;
    end
  end

  // ---------------- final report ----------------
  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check_eq("all_done", {29'd0, g_inst[2].fin, g_inst[1].fin, g_inst[0].fin}, 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
